// File: rtl/pal_macrocell_array.sv
// Programmable AND/OR array with per-output macrocells, loaded through a framed
// serial config port that checks the stream length before enabling outputs.
module pal_macrocell_array #(
    parameter int N_IN    = 8,
    parameter int N_TERMS = 14,
    parameter int N_OUT   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_start,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    input  logic            cfg_last,
    input  logic            run_en,
    input  logic [N_IN-1:0] pal_in,
    output logic [N_OUT-1:0] pal_out,
    output logic            cfg_done,
    output logic            cfg_err
);
    localparam int CFG_LEN = 2*N_IN*N_TERMS + N_TERMS*N_OUT + 2*N_OUT;
    localparam int A       = 2*N_IN*N_TERMS;
    localparam int B       = A + N_TERMS*N_OUT;
    localparam int CW      = $clog2(CFG_LEN+1);

    typedef enum logic [1:0] {IDLE, LOAD, READY, ERROR} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CFG_LEN-1:0]   cfg_q, cfg_d;
    logic [N_OUT-1:0]     mc_q, mc_d;

    logic [N_TERMS-1:0]   term;
    logic [N_OUT-1:0]     v;
    logic                 gate;

    // Product terms: a term with no literal selected is forced to 0.
    for (genvar t = 0; t < N_TERMS; t++) begin : g_term
        logic [N_IN-1:0] ok;
        for (genvar i = 0; i < N_IN; i++) begin : g_lit
            assign ok[i] = (~cfg_q[2*N_IN*t + 2*i]     |  pal_in[i]) &
                           (~cfg_q[2*N_IN*t + 2*i + 1] | ~pal_in[i]);
        end
        assign term[t] = (|cfg_q[2*N_IN*t +: 2*N_IN]) & (&ok);
    end

    assign gate = (state_q == READY) && run_en;

    for (genvar o = 0; o < N_OUT; o++) begin : g_mc
        assign v[o]       = (|(term & cfg_q[A + o*N_TERMS +: N_TERMS])) ^ cfg_q[B + 2*o + 1];
        assign pal_out[o] = gate & (cfg_q[B + 2*o] ? mc_q[o] : v[o]);
    end

    assign cfg_done = (state_q == READY);
    assign cfg_err  = (state_q == ERROR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cfg_d   = cfg_q;
        mc_d    = mc_q;
        if (cfg_start) begin
            // Any bit presented alongside the start pulse is deliberately dropped.
            state_d = LOAD;
            cnt_d   = '0;
            mc_d    = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (cfg_valid) begin
                        cfg_d = {cfg_bit, cfg_q[CFG_LEN-1:1]};
                        cnt_d = cnt_q + CW'(1);
                        if (cfg_last)
                            state_d = (cnt_q == CW'(CFG_LEN-1)) ? READY : ERROR;
                        else if (cnt_q == CW'(CFG_LEN-1))
                            state_d = ERROR;
                    end
                end
                READY: begin
                    if (run_en) mc_d = v;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cfg_q   <= '0;
            mc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cfg_q   <= cfg_d;
            mc_q    <= mc_d;
        end
    end
endmodule

// File: tb/tb_pal_macrocell_array.sv
// Randomized bench for pal_macrocell_array against a behavioural PAL model.
module tb_pal_macrocell_array;
    localparam int N_IN = 8, N_TERMS = 14, N_OUT = 4;
    localparam int CFG_LEN = 2*N_IN*N_TERMS + N_TERMS*N_OUT + 2*N_OUT;
    localparam int A = 2*N_IN*N_TERMS;
    localparam int B = A + N_TERMS*N_OUT;
    localparam int S_IDLE = 0, S_LOAD = 1, S_READY = 2, S_ERR = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0, cfg_start = 1'b0, cfg_valid = 1'b0, cfg_bit = 1'b0, cfg_last = 1'b0;
    logic run_en = 1'b0;
    logic [N_IN-1:0]  pal_in = '0;
    logic [N_OUT-1:0] pal_out;
    logic cfg_done, cfg_err;

    pal_macrocell_array #(.N_IN(N_IN), .N_TERMS(N_TERMS), .N_OUT(N_OUT)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_bit(cfg_bit), .cfg_last(cfg_last), .run_en(run_en), .pal_in(pal_in),
        .pal_out(pal_out), .cfg_done(cfg_done), .cfg_err(cfg_err));

    int n_chk = 0, n_err = 0;
    string phase = "init";

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0h expected %0h", phase, tag, got, exp);
        end
    endtask

    // Model: config held as "stream bit k" array, state as plain integers.
    int mst = S_IDLE, mcnt = 0;
    bit [CFG_LEN-1:0] mcfg = '0;
    bit [N_OUT-1:0]   mflop = '0;

    function automatic bit mv(int o);
        bit sum = 0;
        for (int t = 0; t < N_TERMS; t++) begin
            bit sel = 0, val = 1;
            for (int i = 0; i < N_IN; i++) begin
                if (mcfg[2*N_IN*t + 2*i])     begin sel = 1; if (!pal_in[i]) val = 0; end
                if (mcfg[2*N_IN*t + 2*i + 1]) begin sel = 1; if (pal_in[i])  val = 0; end
            end
            if (sel && val && mcfg[A + o*N_TERMS + t]) sum = 1;
        end
        return sum ^ mcfg[B + 2*o + 1];
    endfunction

    function automatic logic [N_OUT-1:0] mout();
        logic [N_OUT-1:0] r = '0;
        if (mst == S_READY && run_en)
            for (int o = 0; o < N_OUT; o++) r[o] = mcfg[B + 2*o] ? mflop[o] : mv(o);
        return r;
    endfunction

    task automatic check_outs();
        chk("pal_out", pal_out, mout());
        chk("cfg_done", cfg_done, mst == S_READY);
        chk("cfg_err", cfg_err, mst == S_ERR);
    endtask

    task automatic tick();
        int nst = mst, ncnt = mcnt;
        bit [CFG_LEN-1:0] ncfg = mcfg;
        bit [N_OUT-1:0]   nfl = mflop;
        if (!rst_n) begin
            nst = S_IDLE; ncnt = 0; ncfg = '0; nfl = '0;
        end else if (cfg_start) begin
            nst = S_LOAD; ncnt = 0; nfl = '0;
        end else if (mst == S_LOAD && cfg_valid) begin
            ncfg[mcnt] = cfg_bit;
            ncnt = mcnt + 1;
            if (cfg_last) nst = (mcnt == CFG_LEN-1) ? S_READY : S_ERR;
            else if (mcnt == CFG_LEN-1) nst = S_ERR;
        end else if (mst == S_READY && run_en) begin
            for (int o = 0; o < N_OUT; o++) nfl[o] = mv(o);
        end
        @(posedge clk);
        mst = nst; mcnt = ncnt; mcfg = ncfg; mflop = nfl;
        #1;
        check_outs();
    endtask

    // Start pulse (optionally with a colliding bit), then nbits of the stream with random gaps.
    task automatic load(input bit [CFG_LEN-1:0] c, input int nbits, input int last_at, input bit collide);
        cfg_start = 1'b1;
        cfg_valid = collide;
        cfg_bit   = 1'($urandom);
        cfg_last  = 1'b0;
        tick();
        cfg_start = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            while ($urandom_range(0, 3) == 0) begin
                cfg_valid = 1'b0; cfg_last = 1'($urandom); pal_in = N_IN'($urandom);
                tick();
            end
            cfg_valid = 1'b1; cfg_bit = c[k]; cfg_last = (k == last_at);
            pal_in = N_IN'($urandom);
            tick();
        end
        cfg_valid = 1'b0; cfg_last = 1'b0;
    endtask

    bit [CFG_LEN-1:0] c2, c3, cr;

    initial begin
        c2 = '0; c2[0] = 1; c2[2] = 1; c2[A] = 1;
        c3 = '0; c3[2*N_IN*1 + 2*2 + 1] = 1; c3[A + N_TERMS + 1] = 1; c3[B + 2] = 1; c3[B + 3] = 1;

        phase = "reset";
        rst_n = 1'b0;
        repeat (2) begin
            cfg_start = 1'($urandom); cfg_valid = 1'($urandom); cfg_bit = 1'($urandom);
            cfg_last = 1'($urandom); run_en = 1'($urandom); pal_in = N_IN'($urandom);
            tick();
        end
        chk("rst_out", pal_out, 4'b0000);
        chk("rst_done", cfg_done, 1'b0);
        chk("rst_err", cfg_err, 1'b0);
        rst_n = 1'b1; cfg_start = 1'b0;
        repeat (3) begin
            cfg_valid = 1'b1; cfg_last = 1'b1; cfg_bit = 1'($urandom); tick();
        end
        chk("idle_ignores", {cfg_done, cfg_err}, 2'b00);

        phase = "and_comb";
        run_en = 1'b0;
        load(c2, CFG_LEN, CFG_LEN-1, 1'b0);
        chk("done", cfg_done, 1'b1);
        run_en = 1'b1; pal_in = 8'h03; #1;
        chk("in03", pal_out, 4'b0001);
        pal_in = 8'h01; #1;
        chk("in01", pal_out, 4'b0000);
        pal_in = 8'h03; run_en = 1'b0; #1;
        chk("gated", pal_out, 4'b0000);
        tick();

        phase = "reg_inv";
        load(c3, CFG_LEN, CFG_LEN-1, 1'b0);
        run_en = 1'b1; pal_in = 8'h00;
        tick();
        chk("lo", pal_out[1], 1'b0);
        pal_in = 8'h04; #1;
        chk("lat0", pal_out[1], 1'b0);
        tick();
        chk("lat1", pal_out[1], 1'b1);
        run_en = 1'b0; pal_in = 8'h00; #1;
        chk("gated", pal_out[1], 1'b0);
        tick();
        run_en = 1'b1; #1;
        chk("held", pal_out[1], 1'b1);
        tick();

        phase = "err_short";
        for (int k = 0; k < CFG_LEN; k++) cr[k] = 1'($urandom);
        load(cr, 101, 100, 1'b0);
        run_en = 1'b1; pal_in = 8'hff; #1;
        chk("err", {cfg_err, cfg_done, pal_out}, {2'b10, 4'b0000});
        tick();
        phase = "err_long";
        load(cr, CFG_LEN, -1, 1'b0);
        chk("err", {cfg_err, cfg_done}, 2'b10);

        phase = "rst_mid";
        load(cr, 150, -1, 1'b0);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("zero", {cfg_err, cfg_done, pal_out}, 6'b0);
        load(c2, CFG_LEN, CFG_LEN-1, 1'b0);
        run_en = 1'b1; pal_in = 8'h03; #1;
        chk("in03", {cfg_done, pal_out}, 5'b1_0001);
        tick();

        phase = "collide";
        load(c2, CFG_LEN, CFG_LEN-1, 1'b1);
        run_en = 1'b1; pal_in = 8'h03; #1;
        chk("in03", {cfg_done, pal_out}, 5'b1_0001);
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        chk("restart", {cfg_done, pal_out}, 5'b0);
        tick();

        for (int r = 0; r < 6; r++) begin
            phase = $sformatf("rand%0d", r);
            for (int k = 0; k < CFG_LEN; k++)
                cr[k] = (k >= B) ? 1'($urandom) : ($urandom_range(0, 5) == 0);
            load(cr, CFG_LEN, CFG_LEN-1, 1'($urandom));
            repeat (80) begin
                pal_in = N_IN'($urandom);
                run_en = ($urandom_range(0, 4) != 0);
                cfg_valid = ($urandom_range(0, 7) == 0); cfg_last = 1'($urandom);
                tick();
            end
            cfg_valid = 1'b0; cfg_last = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
